register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clock and reset.
REQ-002 Parameter BYPASS_ENABLE, default 1, SHALL select same-cycle write-to-read forwarding (1) or read-old-value behaviour (0).
REQ-003 Parameter COUNTER_WIDTH, default 32, SHALL set the width of write_count.
REQ-004 Ports (name  direction  width  meaning):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- write_enabled  in  1  write request from the write-back stage, already qualified with stage valid
- write_address  in  5  destination register index
- write_strobe  in  4  byte lane enables; bit i covers data bits [8i+7:8i]
- write_data  in  32  write data
- read_address_0  in  5  read port 0 index
- read_data_0  out  32  read port 0 data, combinational
- read_address_1  in  5  read port 1 index
- read_data_1  out  32  read port 1 data, combinational
- written_mask  out  32  bit n is 1 once register n has taken an effective write since reset
- write_count  out  COUNTER_WIDTH  number of effective writes since reset, saturating

Function
REQ-005 Storage SHALL be 32 registers of 32 bits; register 0 SHALL always read 0.
REQ-006 An effective write SHALL be write_enabled=1, write_address!=0 and write_strobe!=0.
REQ-007 On an effective write at a rising clock edge, each byte lane with a strobe bit of 1 SHALL take the corresponding write_data byte, and each lane with a strobe bit of 0 SHALL keep its old value.
REQ-008 A write to address 0, or with write_strobe=4'b0000, SHALL change no storage, no written_mask bit and no write_count.
REQ-009 Write latency SHALL be one edge: data written at edge N SHALL be visible on the read ports from just after edge N, with no bypass needed.
REQ-010 The read ports SHALL be purely combinational from read_address, storage and, when BYPASS_ENABLE=1, the current write inputs.
REQ-011 With BYPASS_ENABLE=1 and a same-cycle effective write whose write_address equals read_address_k (k = 0 or 1), read_data_k SHALL equal the byte-merged value: the write_data byte where the strobe is 1, else the stored byte.
REQ-012 With BYPASS_ENABLE=0, read_data_k SHALL return stored contents only.
REQ-013 Both read ports SHALL be able to address the same register, including the register being written, in the same cycle, with identical results.
REQ-014 Reading address 0 SHALL return 0 even when write_enabled=1 and write_address=0.
REQ-015 On each effective write, written_mask[write_address] SHALL be set to 1 and SHALL never clear except by reset; written_mask[0] SHALL be constant 0.
REQ-016 write_count SHALL increment by 1 per effective write and SHALL saturate at all-ones (no wrap).
REQ-017 The block SHALL accept one write per cycle with no backpressure, so the write-back stage never stalls on it.
REQ-018 X on write_data with write_enabled=0 SHALL NOT propagate to storage or to the read ports.

Reset
REQ-019 While reset is asserted, all 32 registers, written_mask and write_count SHALL be 0, asynchronously and regardless of clock.
REQ-020 Consequently, while reset is asserted, read_data_0 and read_data_1 SHALL be 0 for all addresses when no bypass applies.
REQ-021 Reset asserted in the same cycle as a write SHALL win, and the write SHALL be lost.
REQ-022 After reset deasserts, the first effective write SHALL be taken at the next rising edge.

Verification
REQ-023 Reset, then write r5=0x12345678 with strobe 4'hF, then read r5 on both ports -> 0x12345678; written_mask=0x00000020; write_count=1.
REQ-024 With r5=0x12345678, write r5 with write_data=0xAABBCCDD and strobe 4'b0101, reading r5 in the same cycle -> bypass value 0x12BB56DD (BYPASS_ENABLE=1) or 0x12345678 (BYPASS_ENABLE=0); after the edge, 0x12BB56DD in both configurations.
REQ-025 Write r0=0xFFFFFFFF with strobe 4'hF, and separately write r3 with strobe 4'h0 -> r0 reads 0, r3 is unchanged, and written_mask and write_count are unchanged.
REQ-026 Write 31 registers back-to-back, one per cycle, with read_address_0 tracking write_address -> each read returns its write_data in the same cycle (bypass); afterwards written_mask=0xFFFFFFFE and write_count=31.
REQ-027 With COUNTER_WIDTH=4, perform 20 effective writes -> write_count holds at 4'hF from the 15th write onward.
REQ-028 Assert reset asynchronously between edges while registers hold data -> all reads, written_mask and write_count are 0 immediately; a write presented during reset is not retained.

Source files
------------

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// 32 x 32-bit general-purpose register file for a single-issue pipeline. It has
// one byte-strobed write port, fed by the write-back stage, and two
// combinational read ports. Register 0 is hardwired to zero.
//
// A write is "effective" when write_enabled is set, write_address is non-zero
// and at least one strobe bit is set. Only effective writes change storage,
// written_mask and write_count.
//
// Parameters
//   BYPASS_ENABLE  1: a read that hits the register being written this cycle
//                     returns the byte-merged write value (forwarding).
//                  0: reads return stored contents only.
//   COUNTER_WIDTH  width of write_count. The counter saturates at all-ones.
//
// Ports
//   clock           in   rising-edge clock
//   reset           in   asynchronous active-high reset
//   write_enabled   in   write request (already qualified with stage valid)
//   write_address   in   [4:0]  destination register index
//   write_strobe    in   [3:0]  byte lane enables; bit i covers [8i+7:8i]
//   write_data      in   [31:0] write data
//   read_address_0  in   [4:0]  read port 0 index
//   read_data_0     out  [31:0] read port 0 data (combinational)
//   read_address_1  in   [4:0]  read port 1 index
//   read_data_1     out  [31:0] read port 1 data (combinational)
//   written_mask    out  [31:0] bit n set once register n took an effective write
//   write_count     out  [COUNTER_WIDTH-1:0] effective writes since reset
// -----------------------------------------------------------------------------
module register_file #(
  parameter int BYPASS_ENABLE = 1,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     write_enabled,
  input  logic [4:0]               write_address,
  input  logic [3:0]               write_strobe,
  input  logic [31:0]              write_data,
  input  logic [4:0]               read_address_0,
  output logic [31:0]              read_data_0,
  input  logic [4:0]               read_address_1,
  output logic [31:0]              read_data_1,
  output logic [31:0]              written_mask,
  output logic [COUNTER_WIDTH-1:0] write_count
);

  logic [31:0]              regs_q [0:31];
  logic [31:0]              mask_q;
  logic [31:0]              mask_d;
  logic [COUNTER_WIDTH-1:0] count_q;
  logic [COUNTER_WIDTH-1:0] count_d;

  logic        write_effective;
  logic [31:0] write_merged;

  // Replace only the strobed byte lanes of the old value.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_value,
                                             input logic [31:0] new_value,
                                             input logic [3:0]  strobe);
    logic [31:0] merged;
    merged = old_value;
    for (int lane = 0; lane < 4; lane++) begin
      if (strobe[lane]) merged[8*lane +: 8] = new_value[8*lane +: 8];
    end
    return merged;
  endfunction

  // Write_data is ignored unless the write is effective, so an X on
  // write_data while idle never reaches storage or the read ports.
  assign write_effective = write_enabled && (write_address != 5'd0) && (write_strobe != 4'd0);
  assign write_merged    = byte_merge(regs_q[write_address], write_data, write_strobe);

  // Bit 0 is never set, because an effective write never targets register 0.
  always_comb begin
    mask_d = mask_q;
    if (write_effective) mask_d[write_address] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    if (write_effective && !(&count_q)) count_d = count_q + COUNTER_WIDTH'(1);
  end

  // NOTE: every register is cleared by reset rather than left uninitialised,
  // because software may read any register straight after reset and must see
  // zero. The array therefore maps to flops, not to an SRAM macro.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the
      // pre-edge values regardless of statement order.
      if (write_effective) regs_q[write_address] <= write_merged;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  // NOTE: each read port's output is given a default first, so every path
  // through the block assigns it and no latch is inferred.
  always_comb begin
    read_data_0 = '0;
    if (read_address_0 != 5'd0) begin
      if ((BYPASS_ENABLE != 0) && write_effective && (write_address == read_address_0))
        read_data_0 = write_merged;
      else
        read_data_0 = regs_q[read_address_0];
    end
  end

  always_comb begin
    read_data_1 = '0;
    if (read_address_1 != 5'd0) begin
      if ((BYPASS_ENABLE != 0) && write_effective && (write_address == read_address_1))
        read_data_1 = write_merged;
      else
        read_data_1 = regs_q[read_address_1];
    end
  end

  assign written_mask = mask_q;
  assign write_count  = count_q;

endmodule
